dvi_rx_capture_ctrl: RTL and testbench
======================================

// Module: dvi_rx_capture_ctrl
// PURPOSE
//  Sequences a windowed frame capture from the DVI receiver video stream (rx0 de/vsync/rgb) into a capture RAM.
//  Arms on a host start pulse, optionally skips N frames, then writes a rectangular pixel window as sequential RAM addresses.
//  Sits in the pixel clock domain between the DVI RX decoder and the capture buffer / host readout logic.
// PARAMETERS
//  CNT_W   12  width of pixel/line counters and window fields
//  ADDR_W  16  capture RAM address width
//  VS_POL  1   vsync active level (1 = active-high, 0 = active-low)
// PORTS
//  clk_i      in   1       pixel clock (rx0_pclk)
//  rst_i      in   1       asynchronous reset, active-high
//  start_i    in   1       one-cycle arm request; honoured only in IDLE
//  abort_i    in   1       cancel capture, any state
//  skip_i     in   8       frames to skip before capture
//  x0_i       in   CNT_W   window first pixel column
//  y0_i       in   CNT_W   window first line
//  w_i        in   CNT_W   window width, pixels
//  h_i        in   CNT_W   window height, lines
//  de_i       in   1       video data enable
//  vsync_i    in   1       vertical sync
//  r_i,g_i,b_i in  8 each  pixel colour
//  wr_en_o    out  1       capture RAM write strobe
//  wr_addr_o  out  ADDR_W  capture RAM address
//  wr_data_o  out  24      {r,g,b}
//  busy_o     out  1       high in SYNC/CAPT
//  done_o     out  1       one-cycle pulse, capture finished
//  err_o      out  1       one-cycle pulse, config rejected or frame overrun
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0. Clock is the only clock.
//  - Video inputs registered once (stage 1). Frame start (FS) = stage-1 vsync transition into VS_POL level.
//  - x: counts DE-high pixels of a line, 0 on first DE pixel, cleared while DE low.
//  - y: increments on DE falling edge, cleared on FS.
//  - Window hit = de && x0<=x<x0+w && y0<=y<y0+h; sums computed CNT_W+1 bits, no wrap.
//  - FSM: IDLE, SYNC, CAPT, DONE.
//  - IDLE: start_i latches x0/y0/w/h/skip.
//      w==0, h==0 or w*h>2^ADDR_W -> err_o pulse next cycle, stay IDLE.
//      Otherwise -> SYNC.
//  - SYNC: each FS with skip cnt>0 decrements it; FS with cnt==0 -> CAPT, addr=0.
//      FS in start_i cycle is not counted. skip=0 captures the next whole frame.
//  - CAPT: each hit -> wr_en_o=1, wr_data_o=pixel, wr_addr_o=addr, addr++.
//      Write of addr==w*h-1 -> DONE.
//      FS before completion -> err_o pulse, -> IDLE, no done_o.
//  - DONE: done_o=1 for one cycle -> IDLE.
//  - Latency: pixel at input pins -> wr_en_o/data 2 cycles later; one write per hit, no gaps inserted.
//  - abort_i (any state, priority over all): next cycle IDLE, wr_en_o=0, no done/err.
//  - start_i outside IDLE ignored. start_i and abort_i together in IDLE: abort wins, stays IDLE.
//  - Config inputs sampled only at accepted start; later changes have no effect.
// TESTING
//  - 16x4 frame, x0=2,y0=1,w=4,h=2,skip=0 -> 8 writes addr 0..7, data matches pixels (2..5,1)/(2..5,2), done_o once.
//  - skip=2 -> no wr_en in first two frames after start; capture in third; done_o after 3rd FS + window.
//  - w=0 at start -> err_o pulse 1 cycle later, busy_o stays 0, no writes.
//  - y0=3,h=4 on 4-line frame -> partial writes, next FS gives err_o, no done_o, state IDLE.
//  - abort_i mid-CAPT after 3 writes -> wr_en_o low next cycle, busy_o 0, no done_o; new start accepted.
//  - VS_POL=0 build, vsync active-low stimulus -> identical results to first case.

Source files
------------

// File: rtl/dvi_rx_capture_ctrl.sv
// rtl/dvi_rx_capture_ctrl.sv - windowed DVI frame capture sequencer into capture RAM
// Registers the video once, tracks x/y position and writes the armed window of a chosen frame.
module dvi_rx_capture_ctrl #(
    parameter int CNT_W  = 12,
    parameter int ADDR_W = 16,
    parameter bit VS_POL = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [7:0]        skip_i,
    input  logic [CNT_W-1:0]  x0_i,
    input  logic [CNT_W-1:0]  y0_i,
    input  logic [CNT_W-1:0]  w_i,
    input  logic [CNT_W-1:0]  h_i,
    input  logic              de_i,
    input  logic              vsync_i,
    input  logic [7:0]        r_i,
    input  logic [7:0]        g_i,
    input  logic [7:0]        b_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [23:0]       wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int PROD_W = 2 * CNT_W;
    localparam int CMP_W  = (PROD_W > ADDR_W + 1) ? PROD_W : ADDR_W + 1;
    localparam logic [CMP_W-1:0] MAX_PIX = CMP_W'(1) << ADDR_W;
    localparam logic VS_IDLE = ~VS_POL;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CAPT,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic              de_s1;
    logic              de_s2;
    logic              vs_s1;
    logic              vs_s2;
    logic [23:0]       pix_s1;
    logic [CNT_W-1:0]  x_cnt;
    logic [CNT_W-1:0]  y_cnt;
    logic [CNT_W-1:0]  cfg_x0;
    logic [CNT_W-1:0]  cfg_y0;
    logic [CNT_W-1:0]  cfg_w;
    logic [CNT_W-1:0]  cfg_h;
    logic [7:0]        skip_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] addr;

    logic              fs;
    logic              de_fall;
    logic              hit;
    logic [CNT_W:0]    x_end;
    logic [CNT_W:0]    y_end;
    logic [PROD_W-1:0] req_prod;
    logic              cfg_bad;

    logic              accept;
    logic              reject;
    logic              wr_fire;
    logic              overrun;

    assign fs      = (vs_s1 == VS_POL) && (vs_s2 != VS_POL);
    assign de_fall = de_s2 && !de_s1;

    // Window ends are one bit wider so x0+w never wraps back into range.
    assign x_end = {1'b0, cfg_x0} + {1'b0, cfg_w};
    assign y_end = {1'b0, cfg_y0} + {1'b0, cfg_h};
    assign hit   = de_s1
                && (x_cnt >= cfg_x0) && ({1'b0, x_cnt} < x_end)
                && (y_cnt >= cfg_y0) && ({1'b0, y_cnt} < y_end);

    assign req_prod = PROD_W'(w_i) * PROD_W'(h_i);
    assign cfg_bad  = (w_i == '0) || (h_i == '0) || (CMP_W'(req_prod) > MAX_PIX);

    assign busy_o = (state == ST_SYNC) || (state == ST_CAPT);
    assign done_o = (state == ST_DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            de_s1  <= 1'b0;
            de_s2  <= 1'b0;
            vs_s1  <= VS_IDLE;
            vs_s2  <= VS_IDLE;
            pix_s1 <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            de_s1  <= de_i;
            de_s2  <= de_s1;
            vs_s1  <= vsync_i;
            vs_s2  <= vs_s1;
            pix_s1 <= {r_i, g_i, b_i};
            x_cnt  <= de_s1 ? x_cnt + CNT_W'(1) : '0;
            if (fs) begin
                y_cnt <= '0;
            end else if (de_fall) begin
                y_cnt <= y_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        wr_fire  = 1'b0;
        overrun  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = ST_SYNC;
                    end
                end
            end
            ST_SYNC: begin
                if (fs && (skip_cnt == 8'd0)) begin
                    state_nx = ST_CAPT;
                end
            end
            ST_CAPT: begin
                // A new frame starting before the window is complete means it never fit.
                if (fs) begin
                    overrun  = 1'b1;
                    state_nx = ST_IDLE;
                end else if (hit) begin
                    wr_fire = 1'b1;
                    if (addr == last_addr) begin
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            state_nx = ST_IDLE;
            accept   = 1'b0;
            reject   = 1'b0;
            wr_fire  = 1'b0;
            overrun  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cfg_x0    <= '0;
            cfg_y0    <= '0;
            cfg_w     <= '0;
            cfg_h     <= '0;
            skip_cnt  <= '0;
            last_addr <= '0;
            addr      <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            err_o     <= 1'b0;
        end else begin
            state   <= state_nx;
            wr_en_o <= wr_fire;
            err_o   <= reject | overrun;
            if (accept) begin
                cfg_x0    <= x0_i;
                cfg_y0    <= y0_i;
                cfg_w     <= w_i;
                cfg_h     <= h_i;
                skip_cnt  <= skip_i;
                last_addr <= ADDR_W'(req_prod - PROD_W'(1));
            end
            if (state == ST_SYNC) begin
                addr <= '0;
                if (fs && (skip_cnt != 8'd0)) begin
                    skip_cnt <= skip_cnt - 8'd1;
                end
            end
            if (wr_fire) begin
                wr_addr_o <= addr;
                wr_data_o <= pix_s1;
                addr      <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dvi_rx_capture_ctrl.sv
// tb/tb_dvi_rx_capture_ctrl.sv - vector table plus randomized model check for dvi_rx_capture_ctrl
// Drives both vsync polarities from one stimulus and checks each against a frame-level model.
module tb_dvi_rx_capture_ctrl;

    localparam int PER = 10;

    typedef struct {
        int fw;
        int fh;
        int x0;
        int y0;
        int w;
        int h;
        int skip;
        int start_mode;
        int abort_after;
        int exp_wr;
        int exp_done;
        int exp_err;
    } scen_t;

    typedef struct {
        logic [15:0] addr;
        logic [23:0] data;
        longint      t;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  skip;
    logic [11:0] x0;
    logic [11:0] y0;
    logic [11:0] w;
    logic [11:0] h;
    logic        de;
    logic        vsync;
    logic        vsync_n;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;

    logic        wr_en0, wr_en1;
    logic [15:0] wr_addr0, wr_addr1;
    logic [23:0] wr_data0, wr_data1;
    logic        busy0, busy1, done0, done1, err0, err1;

    assign vsync_n = ~vsync;

    always #(PER / 2) clk = ~clk;

    dvi_rx_capture_ctrl #(.CNT_W(12), .ADDR_W(16), .VS_POL(1'b1)) u_pos (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .skip_i(skip),
        .x0_i(x0), .y0_i(y0), .w_i(w), .h_i(h), .de_i(de), .vsync_i(vsync),
        .r_i(r), .g_i(g), .b_i(b), .wr_en_o(wr_en0), .wr_addr_o(wr_addr0),
        .wr_data_o(wr_data0), .busy_o(busy0), .done_o(done0), .err_o(err0)
    );

    dvi_rx_capture_ctrl #(.CNT_W(12), .ADDR_W(16), .VS_POL(1'b0)) u_neg (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .skip_i(skip),
        .x0_i(x0), .y0_i(y0), .w_i(w), .h_i(h), .de_i(de), .vsync_i(vsync_n),
        .r_i(r), .g_i(g), .b_i(b), .wr_en_o(wr_en1), .wr_addr_o(wr_addr1),
        .wr_data_o(wr_data1), .busy_o(busy1), .done_o(done1), .err_o(err1)
    );

    int checks = 0;
    int failures = 0;

    wr_t    exp_q[$];
    wr_t    got0_q[$];
    wr_t    got1_q[$];
    wr_t    mon_e;
    int     done_n0, done_n1, err_n0, err_n1;
    longint done_t0, done_t1, err_t0, err_t1;
    bit     busy_seen0, busy_seen1;

    int     c_fw, c_fh, c_x0, c_y0, c_w, c_h, c_skip, c_cap_f;
    bit     c_bad;
    int     m_addr, m_total;
    bit     aborted;
    int     abort_after, abort_cd;
    longint t_abort, t_start;

    always @(negedge clk) begin
        if (wr_en0) begin
            mon_e.addr = wr_addr0; mon_e.data = wr_data0; mon_e.t = longint'($time);
            got0_q.push_back(mon_e);
        end
        if (wr_en1) begin
            mon_e.addr = wr_addr1; mon_e.data = wr_data1; mon_e.t = longint'($time);
            got1_q.push_back(mon_e);
        end
        if (done0) begin done_n0++; done_t0 = longint'($time); end
        if (done1) begin done_n1++; done_t1 = longint'($time); end
        if (err0) begin err_n0++; err_t0 = longint'($time); end
        if (err1) begin err_n1++; err_t1 = longint'($time); end
        if (busy0) busy_seen0 = 1'b1;
        if (busy1) busy_seen1 = 1'b1;
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [23:0] pix(input int f, input int l, input int c);
        logic [7:0] pr, pg, pb;
        pr = 8'(f * 41 + l * 7 + 3);
        pg = 8'(c * 13 + l);
        pb = 8'(c ^ (l << 4) ^ f);
        return {pr, pg, pb};
    endfunction

    task automatic clear_mon();
        exp_q.delete(); got0_q.delete(); got1_q.delete();
        done_n0 = 0; done_n1 = 0; err_n0 = 0; err_n1 = 0;
        done_t0 = 0; done_t1 = 0; err_t0 = 0; err_t1 = 0;
        busy_seen0 = 1'b0; busy_seen1 = 1'b0;
    endtask

    task automatic drive_cfg();
        x0 = 12'(c_x0); y0 = 12'(c_y0); w = 12'(c_w); h = 12'(c_h); skip = 8'(c_skip);
    endtask

    // One pixel-clock cycle: inputs are already set; config pins are scrambled afterwards.
    task automatic step();
        bit fired;
        fired = 1'b0;
        if (abort_cd > 0) begin
            abort_cd--;
            if (abort_cd == 0) begin
                abort = 1'b1; fired = 1'b1; aborted = 1'b1; t_abort = longint'($time);
                while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].t > t_abort - 2 * PER)
                    exp_q.delete(exp_q.size() - 1);
            end
        end
        @(negedge clk);
        if (fired) begin
            chk("abort_wr_en_pos", wr_en0, 0);
            chk("abort_wr_en_neg", wr_en1, 0);
            chk("abort_busy_pos", busy0, 0);
            chk("abort_busy_neg", busy1, 0);
        end
        start = 1'b0;
        abort = 1'b0;
        x0 = 12'($urandom); y0 = 12'($urandom); w = 12'($urandom); h = 12'($urandom);
        skip = 8'($urandom);
    endtask

    task automatic drive_frame(input int f, input bit start_now, input bit extra_start);
        de = 1'b0; r = '0; g = '0; b = '0;
        vsync = 1'b1; step();
        vsync = 1'b1;
        if (start_now) begin start = 1'b1; drive_cfg(); t_start = longint'($time); end
        step();
        vsync = 1'b0;
        if (extra_start) start = 1'b1;
        step();
        step();
        for (int l = 0; l < c_fh; l++) begin
            for (int c = 0; c < c_fw; c++) begin
                wr_t e;
                de = 1'b1;
                {r, g, b} = pix(f, l, c);
                if (!c_bad && !aborted && f == c_cap_f && c >= c_x0 && c < c_x0 + c_w
                    && l >= c_y0 && l < c_y0 + c_h && m_addr < m_total) begin
                    e.addr = 16'(m_addr); e.data = pix(f, l, c); e.t = longint'($time);
                    exp_q.push_back(e);
                    m_addr++;
                    if (m_addr == abort_after) abort_cd = 3;
                end
                step();
            end
            de = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic check_dut(input string nm, input wr_t q[$], input int dn, input int en,
                             input bit bs, input longint dt, input longint et, input logic busy_now,
                             input bit use_tab, input scen_t s);
        int  n;
        bit  m_done, m_err;
        m_done = !c_bad && !aborted && (m_addr == m_total);
        m_err  = c_bad || (!aborted && (m_addr != m_total));
        n = (q.size() < exp_q.size()) ? q.size() : exp_q.size();
        chk({nm, "_nwr"}, q.size(), exp_q.size());
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_wr%0d_addr_data", nm, i), {q[i].addr, q[i].data},
                {exp_q[i].addr, exp_q[i].data});
            chk($sformatf("%s_wr%0d_time", nm, i), q[i].t, exp_q[i].t + 2 * PER);
        end
        chk({nm, "_done_cnt"}, dn, m_done);
        chk({nm, "_err_cnt"}, en, m_err);
        chk({nm, "_busy_seen"}, bs, !c_bad);
        chk({nm, "_busy_end"}, busy_now, 0);
        if (m_done && exp_q.size() > 0)
            chk({nm, "_done_time"}, dt, exp_q[exp_q.size() - 1].t + 2 * PER);
        if (c_bad)
            chk({nm, "_reject_time"}, et, t_start + PER);
        if (use_tab) begin
            chk({nm, "_tab_nwr"}, q.size(), s.exp_wr);
            chk({nm, "_tab_done"}, dn, s.exp_done);
            chk({nm, "_tab_err"}, en, s.exp_err);
        end
    endtask

    task automatic run_scen(input scen_t s, input bit use_tab, input string tag);
        int nfr;
        c_fw = s.fw; c_fh = s.fh; c_x0 = s.x0; c_y0 = s.y0; c_w = s.w; c_h = s.h;
        c_skip = s.skip;
        c_bad = (s.w == 0) || (s.h == 0) || (s.w * s.h > 65536);
        c_cap_f = s.skip + s.start_mode;
        m_addr = 0; m_total = s.w * s.h;
        aborted = 1'b0; abort_after = s.abort_after; abort_cd = 0;
        nfr = c_bad ? 1 : c_cap_f + 2;
        clear_mon();
        repeat (4) step();
        if (s.start_mode == 0) begin
            start = 1'b1; drive_cfg(); t_start = longint'($time);
            step();
            step();
        end
        for (int f = 0; f < nfr; f++)
            drive_frame(f, (s.start_mode == 1) && (f == 0),
                        !c_bad && (f > 0 || s.start_mode == 0) && (f <= c_cap_f));
        repeat (6) step();
        check_dut({tag, "_pos"}, got0_q, done_n0, err_n0, busy_seen0, done_t0, err_t0, busy0,
                  use_tab, s);
        check_dut({tag, "_neg"}, got1_q, done_n1, err_n1, busy_seen1, done_t1, err_t1, busy1,
                  use_tab, s);
    endtask

    scen_t tab[10];

    initial begin
        scen_t s;
        //        fw fh x0  y0 w    h    skip sm ab  wr done err
        tab[0] = '{16, 4, 2,  1, 4,   2,   0,  0, -1, 8,  1,  0};
        tab[1] = '{16, 4, 2,  1, 4,   2,   2,  0, -1, 8,  1,  0};
        tab[2] = '{16, 4, 2,  1, 0,   2,   0,  0, -1, 0,  0,  1};
        tab[3] = '{16, 4, 0,  3, 4,   4,   0,  0, -1, 4,  0,  1};
        tab[4] = '{16, 4, 2,  1, 4,   2,   0,  0,  3, 3,  0,  0};
        tab[5] = '{16, 4, 2,  1, 4,   2,   0,  1, -1, 8,  1,  0};
        tab[6] = '{16, 4, 1,  0, 3,   0,   0,  0, -1, 0,  0,  1};
        tab[7] = '{16, 4, 0,  0, 256, 256, 0,  0, -1, 64, 0,  1};
        tab[8] = '{16, 4, 0,  0, 257, 256, 1,  0, -1, 0,  0,  1};
        tab[9] = '{16, 4, 12, 0, 4,   4,   1,  1, -1, 16, 1,  0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; skip = '0;
        x0 = '0; y0 = '0; w = '0; h = '0; de = 1'b0; vsync = 1'b0; r = '0; g = '0; b = '0;
        abort_cd = 0; aborted = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en_pos", wr_en0, 0);
        chk("rst_wr_addr_pos", wr_addr0, 0);
        chk("rst_wr_data_pos", wr_data0, 0);
        chk("rst_busy_pos", busy0, 0);
        chk("rst_done_pos", done0, 0);
        chk("rst_err_pos", err0, 0);
        chk("rst_wr_en_neg", wr_en1, 0);
        chk("rst_wr_addr_neg", wr_addr1, 0);
        chk("rst_wr_data_neg", wr_data1, 0);
        chk("rst_busy_neg", busy1, 0);
        chk("rst_done_neg", done1, 0);
        chk("rst_err_neg", err1, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_scen(tab[i], 1'b1, $sformatf("tab%0d", i));

        // start and abort together in IDLE: abort wins, nothing armed
        clear_mon();
        c_x0 = 2; c_y0 = 1; c_w = 4; c_h = 2; c_skip = 0; c_fw = 16; c_fh = 4;
        start = 1'b1; abort = 1'b1; drive_cfg();
        step();
        chk("startabort_busy_pos", busy0, 0);
        chk("startabort_busy_neg", busy1, 0);
        chk("startabort_err_pos", err0, 0);
        c_bad = 1'b1; aborted = 1'b0; abort_cd = 0; abort_after = -1;
        drive_frame(0, 1'b0, 1'b0);
        repeat (4) step();
        chk("startabort_nwr_pos", got0_q.size(), 0);
        chk("startabort_nwr_neg", got1_q.size(), 0);
        chk("startabort_busy_seen", busy_seen0 | busy_seen1, 0);
        chk("startabort_err_cnt", err_n0 + err_n1, 0);

        for (int i = 0; i < 20; i++) begin
            s.fw = $urandom_range(6, 20);
            s.fh = $urandom_range(3, 8);
            s.x0 = $urandom_range(0, s.fw);
            s.y0 = $urandom_range(0, s.fh);
            s.w = $urandom_range(0, s.fw);
            s.h = $urandom_range(0, s.fh);
            s.skip = $urandom_range(0, 2);
            s.start_mode = $urandom_range(0, 1);
            s.abort_after = -1;
            s.exp_wr = 0; s.exp_done = 0; s.exp_err = 0;
            run_scen(s, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
